// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, controller and fetch state encodings shared by the CPU blocks
package cpu_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDI  = 8'h01;
  localparam logic [7:0] OP_JMP  = 8'h02;
  localparam logic [7:0] OP_CALL = 8'h03;
  localparam logic [7:0] OP_RET  = 8'h04;
  localparam logic [7:0] OP_HLT  = 8'h05;

  typedef enum logic [1:0] {
    CTRL_RESET,
    CTRL_FETCH,
    CTRL_DECODE,
    CTRL_EXEC
  } ctrl_state_t;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_DONE
  } fetch_state_t;

  typedef enum logic {
    K_INST,
    K_IMM
  } fetch_kind_t;

endpackage

// File: rtl/fetch_wait_timer.sv
// rtl/fetch_wait_timer.sv - wait-state counter that flags a dead memory after WAIT_MAX cycles
module fetch_wait_timer #(
  parameter int WAIT_MAX = 7
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [3:0] cnt;

  assign expired = (cnt == 4'(WAIT_MAX));

  // Saturates at WAIT_MAX so a stalled clear cannot wrap the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 4'd0;
    end else if (clear) begin
      cnt <= 4'd0;
    end else if (enable && !expired) begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter owner and instruction/operand fetch handshake
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0,
  parameter int WAIT_MAX = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic              imm_req,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rdy,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        instruction,
  output logic [7:0]        operand,
  output logic              inst_valid,
  output logic              imm_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              bus_err,
  output logic              req_overrun
);

  fetch_state_t      state, state_next;
  fetch_kind_t       kind;
  logic              jmp_pend;
  logic [ADDR_W-1:0] jmp_pend_addr;
  logic              expired;
  logic              timeout;
  logic              any_req;

  fetch_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state != F_REQ),
    .enable  (!mem_rdy),
    .expired (expired)
  );

  assign any_req    = fetch_req || imm_req;
  assign timeout    = (state == F_REQ) && !mem_rdy && expired;
  assign mem_rd     = (state == F_REQ);
  assign mem_addr   = pc;
  assign busy       = (state != F_IDLE);
  assign inst_valid = (state == F_DONE) && (kind == K_INST);
  assign imm_valid  = (state == F_DONE) && (kind == K_IMM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= F_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      F_IDLE:  if (any_req) state_next = F_REQ;
      F_REQ:   if (mem_rdy || timeout) state_next = F_DONE;
      F_DONE:  state_next = F_IDLE;
      default: state_next = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc            <= ADDR_W'(RESET_PC);
      kind          <= K_INST;
      instruction   <= 8'h00;
      operand       <= 8'h00;
      bus_err       <= 1'b0;
      req_overrun   <= 1'b0;
      jmp_pend      <= 1'b0;
      jmp_pend_addr <= '0;
    end else begin
      if ((busy && any_req) || (!busy && fetch_req && imm_req)) req_overrun <= 1'b1;
      case (state)
        F_IDLE: begin
          if (jump_valid) pc <= jump_addr;
          if (fetch_req)    kind <= K_INST;
          else if (imm_req) kind <= K_IMM;
        end
        F_REQ: begin
          if (jump_valid) begin
            jmp_pend      <= 1'b1;
            jmp_pend_addr <= jump_addr;
          end
          if (mem_rdy) begin
            if (kind == K_INST) instruction <= mem_rdata;
            else                operand     <= mem_rdata;
            pc <= pc + 1'b1;
          end else if (expired) begin
            // Feed HLT so the controller parks instead of executing garbage.
            bus_err <= 1'b1;
            if (kind == K_INST) instruction <= OP_HLT;
            else                operand     <= 8'h00;
          end
        end
        F_DONE: begin
          // A jump arriving in DONE itself is newer than any pending one.
          if (jump_valid)    pc <= jump_addr;
          else if (jmp_pend) pc <= jmp_pend_addr;
          jmp_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       fetch_req, imm_req, jump_valid;
  logic [7:0] jump_addr;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic       mem_rdy;
  logic [7:0] mem_rdata;
  logic [7:0] instruction, operand;
  logic       inst_valid, imm_valid;
  logic [7:0] pc;
  logic       busy, bus_err, req_overrun;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.ADDR_W(8), .RESET_PC(0), .WAIT_MAX(7)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .fetch_req   (fetch_req),
    .imm_req     (imm_req),
    .jump_valid  (jump_valid),
    .jump_addr   (jump_addr),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdy     (mem_rdy),
    .mem_rdata   (mem_rdata),
    .instruction (instruction),
    .operand     (operand),
    .inst_valid  (inst_valid),
    .imm_valid   (imm_valid),
    .pc          (pc),
    .busy        (busy),
    .bus_err     (bus_err),
    .req_overrun (req_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_mem_rd"}, 32'(mem_rd), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_pc"}, 32'(pc), 0);
    chk({tag, "_instr"}, 32'(instruction), 0);
    chk({tag, "_operand"}, 32'(operand), 0);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 0);
    chk({tag, "_imm_valid"}, 32'(imm_valid), 0);
    chk({tag, "_bus_err"}, 32'(bus_err), 0);
    chk({tag, "_overrun"}, 32'(req_overrun), 0);
  endtask

  initial begin
    reset_n = 1'b0; fetch_req = 1'b0; imm_req = 1'b0; jump_valid = 1'b0;
    jump_addr = 8'h00; mem_rdy = 1'b0; mem_rdata = 8'h00;
    step(); step();
    check_reset_values("reset");
    reset_n = 1'b1;
    step();

    // Zero-wait instruction fetch from address 0.
    fetch_req = 1'b1; mem_rdy = 1'b1; mem_rdata = 8'h10;
    chk("t1_idle_mem_rd", 32'(mem_rd), 0);
    step();
    fetch_req = 1'b0;
    chk("t1_req_mem_rd", 32'(mem_rd), 1);
    chk("t1_req_addr", 32'(mem_addr), 32'h00);
    chk("t1_req_busy", 32'(busy), 1);
    step();
    mem_rdy = 1'b0;
    chk("t1_done_mem_rd", 32'(mem_rd), 0);
    chk("t1_inst_valid", 32'(inst_valid), 1);
    chk("t1_imm_valid", 32'(imm_valid), 0);
    chk("t1_instr", 32'(instruction), 32'h10);
    chk("t1_pc", 32'(pc), 1);
    step();
    chk("t1_idle_valid", 32'(inst_valid), 0);
    chk("t1_idle_busy", 32'(busy), 0);

    // Operand fetch with three wait states.
    imm_req = 1'b1; mem_rdata = 8'h3C;
    step();
    imm_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_wait_mem_rd", 32'(mem_rd), 1);
      chk("t2_wait_addr", 32'(mem_addr), 32'h01);
      chk("t2_wait_no_valid", 32'(imm_valid), 0);
      step();
    end
    mem_rdy = 1'b1;
    chk("t2_rdy_mem_rd", 32'(mem_rd), 1);
    step();
    mem_rdy = 1'b0;
    chk("t2_imm_valid", 32'(imm_valid), 1);
    chk("t2_inst_valid", 32'(inst_valid), 0);
    chk("t2_operand", 32'(operand), 32'h3C);
    chk("t2_instr_held", 32'(instruction), 32'h10);
    chk("t2_pc", 32'(pc), 2);
    step();
    chk("t2_pulse_end", 32'(imm_valid), 0);

    // PC wrap: jump to 0xFF alone, then fetch.
    jump_valid = 1'b1; jump_addr = 8'hFF;
    step();
    jump_valid = 1'b0;
    chk("t3_jump_pc", 32'(pc), 32'hFF);
    chk("t3_jump_busy", 32'(busy), 0);
    fetch_req = 1'b1; mem_rdy = 1'b1; mem_rdata = 8'hAA;
    step();
    fetch_req = 1'b0;
    chk("t3_addr_ff", 32'(mem_addr), 32'hFF);
    step();
    mem_rdy = 1'b0;
    chk("t3_instr", 32'(instruction), 32'hAA);
    chk("t3_pc_wrap", 32'(pc), 32'h00);
    step();

    // Jump and fetch in the same idle cycle.
    jump_valid = 1'b1; jump_addr = 8'h40; fetch_req = 1'b1; mem_rdy = 1'b1; mem_rdata = 8'h77;
    step();
    jump_valid = 1'b0; fetch_req = 1'b0;
    chk("t4_addr_jump", 32'(mem_addr), 32'h40);
    step();
    mem_rdy = 1'b0;
    chk("t4_instr", 32'(instruction), 32'h77);
    chk("t4_pc", 32'(pc), 32'h41);
    step();

    // Jump during REQ is deferred; a request while busy is dropped.
    chk("t5_overrun_clear", 32'(req_overrun), 0);
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    jump_valid = 1'b1; jump_addr = 8'h80;
    chk("t5_addr_old", 32'(mem_addr), 32'h41);
    step();
    jump_valid = 1'b0; fetch_req = 1'b1;
    mem_rdy = 1'b1; mem_rdata = 8'h22;
    chk("t5_addr_still_old", 32'(mem_addr), 32'h41);
    step();
    fetch_req = 1'b0; mem_rdy = 1'b0;
    chk("t5_instr", 32'(instruction), 32'h22);
    chk("t5_pc_incr", 32'(pc), 32'h42);
    chk("t5_overrun_set", 32'(req_overrun), 1);
    step();
    chk("t5_pc_jump", 32'(pc), 32'h80);
    chk("t5_busy_ignored", 32'(busy), 0);
    step();
    chk("t5_still_idle", 32'(busy), 0);
    chk("t5_overrun_sticky", 32'(req_overrun), 1);

    // Instruction timeout on a dead memory.
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t6_wait_mem_rd", 32'(mem_rd), 1);
      chk("t6_wait_no_valid", 32'(inst_valid), 0);
      chk("t6_wait_no_err", 32'(bus_err), 0);
      step();
    end
    chk("t6_inst_valid", 32'(inst_valid), 1);
    chk("t6_instr_hlt", 32'(instruction), 32'h05);
    chk("t6_bus_err", 32'(bus_err), 1);
    chk("t6_pc_unchanged", 32'(pc), 32'h80);
    step();

    // Operand timeout substitutes zero.
    imm_req = 1'b1;
    step();
    imm_req = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("t7_imm_valid", 32'(imm_valid), 1);
    chk("t7_operand_zero", 32'(operand), 32'h00);
    chk("t7_pc_unchanged", 32'(pc), 32'h80);
    step();

    // Reset asserted in the middle of REQ.
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("t8_req_mem_rd", 32'(mem_rd), 1);
    #2 reset_n = 1'b0;
    #1;
    check_reset_values("t8_async");
    step();
    reset_n = 1'b1;
    step();

    // Simultaneous fetch and imm: fetch wins, overrun flagged.
    fetch_req = 1'b1; imm_req = 1'b1; mem_rdy = 1'b1; mem_rdata = 8'h5A;
    step();
    fetch_req = 1'b0; imm_req = 1'b0;
    chk("t9_addr", 32'(mem_addr), 32'h00);
    step();
    mem_rdy = 1'b0;
    chk("t9_inst_valid", 32'(inst_valid), 1);
    chk("t9_imm_valid", 32'(imm_valid), 0);
    chk("t9_instr", 32'(instruction), 32'h5A);
    chk("t9_operand", 32'(operand), 32'h00);
    chk("t9_overrun", 32'(req_overrun), 1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction/operand fetch stage sitting directly upstream of the CPU control FSM. It owns the program counter and runs a request/ready read handshake with program RAM. It also captures the fetched byte as either the instruction byte (fed to the controller's `instruction` input) or an immediate operand byte (for LDI/JMP/CALL). A bounded wait-state timeout substitutes HLT on a dead memory so the controller stops cleanly.

## Interface
- `ADDR_W`, 8, program counter / RAM address width
- `RESET_PC`, 0, PC value after reset
- `WAIT_MAX`, 7, maximum cycles to wait for `mem_rdy` before abort (1..15)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `fetch_req`  in  1  one-cycle pulse from controller: fetch instruction byte at PC
- `imm_req`  in  1  one-cycle pulse: fetch operand byte at PC
- `jump_valid`  in  1  load PC from `jump_addr`
- `jump_addr`  in  ADDR_W  jump target
- `mem_rd`  out  1  read request to RAM
- `mem_addr`  out  ADDR_W  read address
- `mem_rdy`  in  1  RAM data valid this cycle
- `mem_rdata`  in  8  RAM read data
- `instruction`  out  8  last captured instruction byte, held
- `operand`  out  8  last captured operand byte, held
- `inst_valid`  out  1  one-cycle pulse: `instruction` updated
- `imm_valid`  out  1  one-cycle pulse: `operand` updated
- `pc`  out  ADDR_W  current program counter
- `busy`  out  1  high in any state other than IDLE
- `bus_err`  out  1  sticky: a timeout occurred
- `req_overrun`  out  1  sticky: request arrived while busy

## Operation
- States: IDLE, REQ, DONE. Register `kind` (INST/IMM) records the access type.
- IDLE: `busy`=0. `fetch_req` → REQ, kind=INST. `imm_req` → REQ, kind=IMM. If both are asserted, `fetch_req` wins, `imm_req` is dropped, and `req_overrun` is set.
- REQ: `mem_rd`=1 and `mem_addr`=`pc`. Stays in REQ until `mem_rdy` is sampled high. On that edge:
  - `mem_rdata` is stored in `instruction` (INST) or `operand` (IMM).
  - `pc` ← `pc`+1, wrapping modulo 2^ADDR_W (0xFF → 0x00).
  - Next state is DONE.
- Timeout: the wait counter starts at 0 on entry to REQ and increments each cycle that `mem_rdy` is low. When it reaches WAIT_MAX with `mem_rdy` low:
  - `bus_err` ← 1.
  - INST: `instruction` ← 8'h05 (OP_HLT). IMM: `operand` ← 8'h00.
  - `pc` is not incremented.
  - Next state is DONE.
- DONE: pulse `inst_valid` or `imm_valid` according to kind, then return to IDLE.
- Jumps:
  - `jump_valid` in IDLE: `pc` ← `jump_addr` on that edge. If `fetch_req`/`imm_req` arrives in the same cycle, the access uses `jump_addr`.
  - `jump_valid` in REQ/DONE: target is latched into a pending register. It is applied on the DONE→IDLE edge and overrides the increment. The in-flight access completes at its old address. A later jump overwrites an earlier pending one.
- `fetch_req`/`imm_req` while `busy`=1 are ignored and set `req_overrun`.
- `mem_rd` is never asserted outside REQ. `mem_addr` equals `pc` in every state.

## Timing
- Reset values (async assert, sync release):
  - state=IDLE, `pc`=RESET_PC.
  - `instruction`=0, `operand`=0.
  - `inst_valid`=`imm_valid`=`mem_rd`=`busy`=0.
  - `bus_err`=`req_overrun`=0, pending jump cleared.
- Reset during REQ aborts the access immediately: `mem_rd` drops asynchronously and no valid pulse is issued.
- Latency with zero wait states: request in cycle n → REQ in n+1 with `mem_rdy`=1 → valid pulse in n+2 → IDLE in n+3. Each wait state adds one cycle.
- Throughput: at most one access per 3 cycles. The next request is accepted in the cycle `busy` returns low.
- Timeout case: valid pulse occurs WAIT_MAX+1 cycles after REQ entry.
- `instruction`/`operand` change only on the capture edge. They are stable while the valid pulse is high and until the next capture.

## Structure
- Shared package `cpu_pkg`: opcode constants (OP_NOP, OP_HLT=8'h05, …), controller state encodings, and a `fetch_state_t` enum, all shared with `cpu_ctrl`.
- One sub-module is natural: `fetch_wait_timer`, the WAIT_MAX counter with clear/enable/expired signals. Everything else stays in `fetch_unit`.

## Test plan
- Reset, then `fetch_req`, RAM[0]=8'h10 with zero wait → `mem_rd` high 1 cycle, `instruction`=8'h10, `inst_valid` at n+2, `pc`=1.
- `imm_req` with `mem_rdy` delayed 3 cycles, RAM[1]=8'h3C → `mem_rd` held 4 cycles, `operand`=8'h3C, `imm_valid` one pulse, `pc`=2.
- `pc`=8'hFF, `fetch_req` → fetch from 8'hFF, `pc` wraps to 8'h00.
- `mem_rdy` tied low, WAIT_MAX=7 → `instruction`=8'h05 and `inst_valid` 8 cycles after REQ entry, `bus_err`=1, `pc` unchanged.
- `jump_valid` with `jump_addr`=8'h40 and `fetch_req` in the same IDLE cycle → `mem_addr`=8'h40 then `pc`=8'h41. `jump_valid`=8'h80 during REQ → access completes at the old address, `pc`=8'h80 after DONE.
- `fetch_req` while busy → ignored, `req_overrun`=1 sticky. Assert `reset_n` low mid-REQ → `mem_rd`=0 immediately and all outputs at reset values.
